// File: rtl/arith_pkg.sv
// Shared arithmetic package for the bit-serial subtractor.
// Holds the FSM state type and the helper that sizes the bit counter.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Bit-index counter width for an n-bit operand (n >= 2, so $clog2 >= 1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subtractor_nbit_serial_if.sv
// Handshake/data bundle for subtractor_nbit_serial.
//   start, x, y, b_in          : request and operands (master -> slave)
//   busy, done, diff, b_out, ovf : status and result (slave -> master)
interface subtractor_nbit_serial_if #(
  parameter int N = 4
);

  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
  logic         ovf;

  modport master (
    output start, x, y, b_in,
    input  busy, done, diff, b_out, ovf
  );

  modport slave (
    input  start, x, y, b_in,
    output busy, done, diff, b_out, ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, bo = borrow out.
//   a, b, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/subtractor_nbit_serial.sv
// Bit-serial N-bit subtractor: diff = x - y - b_in, one bit per clock, LSB
// first, through one full_subtractor cell and a borrow flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : start/x/y/b_in in; busy/done/diff/b_out/ovf out (all registered)
// Latency is N+1 edges from the accepting edge to the done cycle; a start
// seen in DONE is accepted directly, giving an N+1 cycle back-to-back period.
module subtractor_nbit_serial
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  subtractor_nbit_serial_if.slave   bus
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  sub_state_t    state_q, state_d;
  logic [N-1:0]  xs_q, xs_d;
  logic [N-1:0]  ys_q, ys_d;
  // Holds the N-1 difference bits produced so far; the last bit comes
  // straight from the cell at completion.
  logic [N-2:0]  ds_q, ds_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xn_q, xn_d;
  logic          yn_q, yn_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          b_out_q, b_out_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          cell_diff;
  logic          cell_borrow;
  logic [N-1:0]  ds_ext;

  full_subtractor u_cell (
    .a  (xs_q[0]),
    .b  (ys_q[0]),
    .bi (borrow_q),
    .d  (cell_diff),
    .bo (cell_borrow)
  );

  assign ds_ext = {cell_diff, ds_q};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    ds_d     = ds_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    xn_d     = xn_q;
    yn_d     = yn_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          xs_d     = bus.x;
          ys_d     = bus.y;
          borrow_d = bus.b_in;
          cnt_d    = '0;
          xn_d     = bus.x[N-1];
          yn_d     = bus.y[N-1];
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        xs_d     = {1'b0, xs_q[N-1:1]};
        ys_d     = {1'b0, ys_q[N-1:1]};
        ds_d     = ds_ext[N-1:1];
        borrow_d = cell_borrow;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          diff_d  = ds_ext;
          b_out_d = cell_borrow;
          // Overflow only possible when signs differ and the result sign
          // departs from the minuend sign.
          ovf_d   = (xn_q ^ yn_q) & (xn_q ^ cell_diff);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      ds_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      xn_q     <= 1'b0;
      yn_q     <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      ds_q     <= ds_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      xn_q     <= xn_d;
      yn_q     <= yn_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_subtractor_nbit_serial.sv
// Self-checking bench for subtractor_nbit_serial (N=4 and N=8 instances).
module tb_subtractor_nbit_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  subtractor_nbit_serial_if #(.N(4)) if4 ();
  subtractor_nbit_serial_if #(.N(8)) if8 ();

  subtractor_nbit_serial #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  subtractor_nbit_serial #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  // Arithmetic reference: unsigned modular difference, unsigned borrow,
  // signed range overflow.
  function automatic void model(input int n, input int x, input int y, input int b,
                                output int d, output bit bo, output bit ov);
    int m, sx, sy, r;
    m  = 1 << n;
    d  = (((x - y - b) % m) + m) % m;
    bo = (x < (y + b));
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    r  = sx - sy - b;
    ov = (r < -(m / 2)) || (r > (m / 2 - 1));
  endfunction

  task automatic check4(input string tag, input int x, input int y, input int b);
    int d; bit bo, ov;
    model(4, x, y, b, d, bo, ov);
    tests++;
    if (if4.diff !== 4'(d)) begin
      fails++; $display("FAIL %s diff4: got %0h want %0h", tag, if4.diff, d);
    end
    tests++;
    if (if4.b_out !== bo) begin
      fails++; $display("FAIL %s b_out4: got %0b want %0b", tag, if4.b_out, bo);
    end
    tests++;
    if (if4.ovf !== ov) begin
      fails++; $display("FAIL %s ovf4: got %0b want %0b", tag, if4.ovf, ov);
    end
  endtask

  task automatic op4(input int x, input int y, input int b, input string tag);
    int k;
    @(negedge clk);
    if4.start = 1'b1; if4.x = 4'(x); if4.y = 4'(y); if4.b_in = 1'(b);
    @(negedge clk);
    if4.start = 1'b0; if4.x = 4'($urandom); if4.y = 4'($urandom); if4.b_in = 1'($urandom);
    k = 1;
    tests++;
    if (if4.busy !== 1'b1) begin
      fails++; $display("FAIL %s busy_after_accept: got %0b want 1", tag, if4.busy);
    end
    while (if4.done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tests++;
    if (if4.done !== 1'b1 || k != 5) begin
      fails++; $display("FAIL %s latency4: got %0d want 5", tag, k);
    end
    check4(tag, x, y, b);
    @(negedge clk);
    tests++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
      fails++; $display("FAIL %s idle_after_done: got done=%0b busy=%0b want 0 0", tag, if4.done, if4.busy);
    end
  endtask

  task automatic op8(input int x, input int y, input int b, input string tag);
    int k; int d; bit bo, ov;
    model(8, x, y, b, d, bo, ov);
    @(negedge clk);
    if8.start = 1'b1; if8.x = 8'(x); if8.y = 8'(y); if8.b_in = 1'(b);
    @(negedge clk);
    if8.start = 1'b0; if8.x = 8'($urandom); if8.y = 8'($urandom);
    k = 1;
    while (if8.done !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    tests++;
    if (if8.done !== 1'b1 || k != 9) begin
      fails++; $display("FAIL %s latency8: got %0d want 9", tag, k);
    end
    tests++;
    if (if8.diff !== 8'(d) || if8.b_out !== bo || if8.ovf !== ov) begin
      fails++;
      $display("FAIL %s result8: got diff=%0h b=%0b o=%0b want diff=%0h b=%0b o=%0b",
               tag, if8.diff, if8.b_out, if8.ovf, d, bo, ov);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.diff !== 4'h0 ||
        if4.b_out !== 1'b0 || if4.ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s zero4: got busy=%0b done=%0b diff=%0h b=%0b o=%0b want all 0",
               tag, if4.busy, if4.done, if4.diff, if4.b_out, if4.ovf);
    end
    tests++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.diff !== 8'h00 ||
        if8.b_out !== 1'b0 || if8.ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s zero8: got busy=%0b done=%0b diff=%0h b=%0b o=%0b want all 0",
               tag, if8.busy, if8.done, if8.diff, if8.b_out, if8.ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if4.start = 1'b0; if4.x = '0; if4.y = '0; if4.b_in = 1'b0;
    if8.start = 1'b0; if8.x = '0; if8.y = '0; if8.b_in = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_directed();
    op4(9, 3, 0, "d_9_3");
    op4(3, 9, 0, "d_3_9");
    op4(0, 0, 1, "d_0_0_b");
    op4(8, 1, 0, "d_8_1");
    op4(15, 15, 1, "d_f_f_b");
    op4(7, 8, 0, "d_7_8");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), "rand4");
    for (int i = 0; i < 8; i++)
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rand8");
  endtask

  task automatic test_start_during_run();
    int pulses;
    @(negedge clk);
    if4.start = 1'b1; if4.x = 4'd5; if4.y = 4'd2; if4.b_in = 1'b0;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    if4.start = 1'b1; if4.x = 4'd1; if4.y = 4'd7; if4.b_in = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    pulses = 0;
    for (int k = 3; k < 14; k++) begin
      if (if4.done === 1'b1) begin
        pulses++;
        check4("run_start_ignored", 5, 2, 0);
      end
      @(negedge clk);
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL run_start_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int k, j;
    @(negedge clk);
    if4.start = 1'b1; if4.x = 4'd12; if4.y = 4'd5; if4.b_in = 1'b1;
    @(negedge clk);
    if4.x = 4'd2; if4.y = 4'd6; if4.b_in = 1'b0;
    k = 1;
    while (if4.done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tests++;
    if (if4.done !== 1'b1 || k != 5) begin
      fails++; $display("FAIL b2b_first_latency: got %0d want 5", k);
    end
    check4("b2b_first", 12, 5, 1);
    @(negedge clk);
    if4.start = 1'b0;
    j = 1;
    tests++;
    if (if4.busy !== 1'b1 || if4.done !== 1'b0) begin
      fails++; $display("FAIL b2b_no_idle: got busy=%0b done=%0b want 1 0", if4.busy, if4.done);
    end
    while (if4.done !== 1'b1 && j < 20) begin @(negedge clk); j++; end
    tests++;
    if (if4.done !== 1'b1 || j != 5) begin
      fails++; $display("FAIL b2b_period: got %0d want 5", j);
    end
    check4("b2b_second", 2, 6, 0);
    @(negedge clk);
    tests++;
    if (if4.busy !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: got busy=%0b want 0", if4.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int stray;
    @(negedge clk);
    if4.start = 1'b1; if4.x = 4'd11; if4.y = 4'd2; if4.b_in = 1'b0;
    if8.start = 1'b1; if8.x = 8'hA5; if8.y = 8'h3C; if8.b_in = 1'b1;
    @(negedge clk);
    if4.start = 1'b0; if8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_op");
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if4.done !== 1'b0 || if8.done !== 1'b0 || if4.busy !== 1'b0 || if8.busy !== 1'b0)
        stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++; $display("FAIL reset_no_done: got %0d active cycles want 0", stray);
    end
    op8(0, 1, 0, "fresh8");
    op4(0, 1, 0, "fresh4");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
